// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI-lite data memory: response codes, read and
// write channel state encodings, delay-counter width and the address window
// test used by both channels.
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Response delay is 0..31 cycles, so the counters are five bits wide.
    localparam int DLY_W = 5;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    // True when base <= addr < base + 4*depth. Done in 33 bits so a window
    // ending exactly at the top of the address space does not wrap.
    function automatic logic addr_in_range(input logic [31:0]   addr,
                                           input logic [31:0]   base,
                                           input int unsigned   depth);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'(depth) << 2);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/axi_lite_sram_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1,
// seeded with 16'hACE1 on reset and advancing every clock. Supplies the
// random response delay of axi_lite_sram when AXI_SRAM_RAND_DELAY_EN is set.
//
// Ports:
//   clk  in   1   clock
//   rst  in   1   synchronous active-high reset (reloads the seed)
//   q    out  16  current LFSR state
// -----------------------------------------------------------------------------
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    localparam logic [15:0] SEED = 16'hACE1;

    // NOTE: clocked state is always assigned with <= so every register in the
    // design samples its inputs from before the edge, independent of the
    // order in which always blocks are evaluated.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
        end
    end

endmodule

// File: rtl/axi_lite_sram.sv
// -----------------------------------------------------------------------------
// axi_lite_sram
// AXI-lite slave data memory for the write-back stage memory port. Independent
// read (ar/r) and write (aw/w/b) state machines share one word-addressed
// array. Each channel holds at most one transaction. The response comes
// 1+d cycles after the address (read) or the later of aw/w (write) is
// accepted, where d is FIXED_LAT, or a fresh LFSR sample when the build
// macro AXI_SRAM_RAND_DELAY_EN is defined.
//
// Parameters:
//   DEPTH      number of 32-bit words (power of two)
//   BASE       byte address of word 0
//   FIXED_LAT  response delay d when random delay is not compiled in (0..31)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel (wstrb[7:4] ignored)
//   bresp/bvalid/bready       write response channel
// -----------------------------------------------------------------------------
module axi_lite_sram #(
    parameter int unsigned DEPTH     = 4096,
    parameter logic [31:0] BASE      = 32'h8000_0000,
    parameter int unsigned FIXED_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    import axi_lite_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    // ---------------------------------------------------------------- delay
    logic [DLY_W-1:0] delay_rd;
    logic [DLY_W-1:0] delay_wr;

`ifdef AXI_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    // Each channel samples the shared LFSR on its own capture cycle.
    assign delay_rd    = lfsr_q[DLY_W-1:0];
    assign delay_wr    = lfsr_q[DLY_W-1:0];
    assign unused_lfsr = ^lfsr_q[15:DLY_W];
`else
    assign delay_rd = DLY_W'(FIXED_LAT);
    assign delay_wr = DLY_W'(FIXED_LAT);
`endif

    logic unused_wstrb;
    assign unused_wstrb = ^wstrb[7:4];

    // ----------------------------------------------------------- read side
    rd_state_t        rd_state;
    logic [DLY_W-1:0] rd_cnt;
    logic [31:0]      rd_addr_q;
    logic [31:0]      rd_addr_eff;
    logic             rd_in_range;
    logic [IDX_W-1:0] rd_idx;
    logic             ar_hs;

    // Ready is a decode of the state, forced low while reset is held.
    assign arready = (rd_state == R_IDLE) && !rst;
    assign ar_hs   = arvalid && arready;

    // With zero delay the array is read on the capture edge itself, before
    // the address register has been loaded.
    assign rd_addr_eff = (rd_state == R_IDLE) ? araddr : rd_addr_q;
    assign rd_in_range = addr_in_range(rd_addr_eff, BASE, DEPTH);
    assign rd_idx      = IDX_W'((rd_addr_eff - BASE) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= R_IDLE;
            rd_cnt    <= '0;
            rd_addr_q <= '0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= RESP_OKAY;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_addr_q <= araddr;
                        if (delay_rd == '0) begin
                            rdata    <= rd_in_range ? mem[rd_idx] : '0;
                            rresp    <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                            rvalid   <= 1'b1;
                            rd_state <= R_RESP;
                        end else begin
                            rd_cnt   <= delay_rd;
                            rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (rd_cnt == DLY_W'(1)) begin
                        rdata    <= rd_in_range ? mem[rd_idx] : '0;
                        rresp    <= rd_in_range ? RESP_OKAY : RESP_DECERR;
                        rvalid   <= 1'b1;
                        rd_state <= R_RESP;
                    end else begin
                        rd_cnt <= rd_cnt - DLY_W'(1);
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid   <= 1'b0;
                        rd_state <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------- write side
    wr_state_t        wr_state;
    logic [DLY_W-1:0] wr_cnt;
    logic             aw_got;
    logic             w_got;
    logic [31:0]      wr_addr_q;
    logic [31:0]      wr_data_q;
    logic [3:0]       wr_strb_q;
    logic             aw_hs;
    logic             w_hs;
    logic             wr_both;
    logic [31:0]      wr_addr_eff;
    logic [31:0]      wr_data_eff;
    logic [3:0]       wr_strb_eff;
    logic             wr_in_range;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_enter_resp;
    logic             mem_we;

    assign awready = (wr_state == W_IDLE) && !aw_got && !rst;
    assign wready  = (wr_state == W_IDLE) && !w_got && !rst;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;

    // Both halves are in hand this cycle, whether captured earlier or now.
    assign wr_both = (aw_got || aw_hs) && (w_got || w_hs);

    // The capture flags stay set until the response completes, so the
    // registered copy is selected whenever it is valid.
    assign wr_addr_eff = aw_got ? wr_addr_q : awaddr;
    assign wr_data_eff = w_got  ? wr_data_q : wdata;
    assign wr_strb_eff = w_got  ? wr_strb_q : wstrb[3:0];
    assign wr_in_range = addr_in_range(wr_addr_eff, BASE, DEPTH);
    assign wr_idx      = IDX_W'((wr_addr_eff - BASE) >> 2);

    // The commit happens on the edge that enters W_RESP; reset on that edge
    // drops the write.
    assign wr_enter_resp = !rst &&
                           (((wr_state == W_IDLE) && wr_both && (delay_wr == '0)) ||
                            ((wr_state == W_WAIT) && (wr_cnt == DLY_W'(1))));
    assign mem_we = wr_enter_resp && wr_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state  <= W_IDLE;
            wr_cnt    <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_strb_q <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_got    <= 1'b1;
                        wr_addr_q <= awaddr;
                    end
                    if (w_hs) begin
                        w_got     <= 1'b1;
                        wr_data_q <= wdata;
                        wr_strb_q <= wstrb[3:0];
                    end
                    if (wr_both) begin
                        if (delay_wr == '0) begin
                            bresp    <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                            bvalid   <= 1'b1;
                            wr_state <= W_RESP;
                        end else begin
                            wr_cnt   <= delay_wr;
                            wr_state <= W_WAIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_cnt == DLY_W'(1)) begin
                        bresp    <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                        bvalid   <= 1'b1;
                        wr_state <= W_RESP;
                    end else begin
                        wr_cnt <= wr_cnt - DLY_W'(1);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid   <= 1'b0;
                        aw_got   <= 1'b0;
                        w_got    <= 1'b0;
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // NOTE: the storage array has no reset branch; clearing thousands of
    // words is not wanted and would stop it mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb_eff[k]) begin
                    mem[wr_idx][8*k +: 8] <= wr_data_eff[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_sram
// Self-checking bench for axi_lite_sram. Instance u_dut_a uses FIXED_LAT=0,
// instance u_dut_b uses FIXED_LAT=3; each is held in reset while the other is
// exercised, and the shared input bus is steered to whichever is selected.
// -----------------------------------------------------------------------------
module tb_axi_lite_sram;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic [7:0]  wstrb;

    logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
    logic [31:0] rdata_a;
    logic [1:0]  rresp_a, bresp_a;
    logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b;
    logic [31:0] rdata_b;
    logic [1:0]  rresp_b, bresp_b;

    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp, s_bresp;

    assign s_arready = sel ? arready_b : arready_a;
    assign s_rvalid  = sel ? rvalid_b  : rvalid_a;
    assign s_awready = sel ? awready_b : awready_a;
    assign s_wready  = sel ? wready_b  : wready_a;
    assign s_bvalid  = sel ? bvalid_b  : bvalid_a;
    assign s_rdata   = sel ? rdata_b   : rdata_a;
    assign s_rresp   = sel ? rresp_b   : rresp_a;
    assign s_bresp   = sel ? bresp_b   : bresp_a;

    axi_lite_sram #(.DEPTH(DEPTH), .BASE(BASE), .FIXED_LAT(0)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_a),
        .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_a),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_a),
        .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready)
    );

    axi_lite_sram #(.DEPTH(DEPTH), .BASE(BASE), .FIXED_LAT(3)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .araddr(araddr), .arvalid(arvalid), .arready(arready_b),
        .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready_b),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_b),
        .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Latency is counted from the capture cycle: 1 means valid on the next cycle.
    task automatic check_lat(input string name, input int lat, input int fixed);
`ifdef AXI_SRAM_RAND_DELAY_EN
        check(name, 32'(lat >= 1 && lat <= 32), 32'd1);
`else
        check(name, 32'(lat), 32'(fixed + 1));
`endif
    endtask

    // ------------------------------------------------------------ reference
    logic [7:0] bmem [int unsigned];

    function automatic bit m_in_range(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    // ---------------------------------------------------------- bus tasks
    // w_lead > 0: w is offered that many cycles before aw; < 0: aw leads.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int w_lead, input int b_hold,
                            output logic [1:0] resp, output int lat, output bit ok);
        int aw_start, w_start, n;
        bit aw_done, w_done, stable;
        logic [1:0] r0;
        ok = 0; resp = 2'b00; lat = 0;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        aw_done = 0; w_done = 0; n = 0;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; bready = 1'b0;
        while (!(aw_done && w_done)) begin
            if (n > 50) begin
                check("wr_capture_timeout", 32'd0, 32'd1);
                awvalid = 1'b0; wvalid = 1'b0;
                return;
            end
            awvalid = !aw_done && (n >= aw_start);
            wvalid  = !w_done && (n >= w_start);
            @(negedge clk);
            if (w_done && !aw_done) check("wready_low_after_w", 32'(s_wready), 32'd0);
            if (aw_done && !w_done) check("awready_low_after_aw", 32'(s_awready), 32'd0);
            if (awvalid && s_awready) aw_done = 1;
            if (wvalid && s_wready)   w_done  = 1;
            @(posedge clk); #1;
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!s_bvalid) begin
            if (lat >= 40) begin
                check("bvalid_timeout", 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
            lat++;
        end
        r0 = s_bresp; stable = 1;
        repeat (b_hold) begin
            @(negedge clk);
            if (!s_bvalid || s_bresp !== r0) stable = 0;
        end
        if (b_hold > 0) check("bvalid_bresp_held", 32'(stable), 32'd1);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        resp = r0; ok = 1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_hold,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit ok);
        int n;
        bit stable;
        ok = 0; data = '0; resp = 2'b00; lat = 0; n = 0;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        while (!s_arready) begin
            if (n > 50) begin
                check("ar_capture_timeout", 32'd0, 32'd1);
                arvalid = 1'b0;
                return;
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!s_rvalid) begin
            if (lat >= 40) begin
                check("rvalid_timeout", 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
            lat++;
        end
        data = s_rdata; resp = s_rresp; stable = 1;
        repeat (r_hold) begin
            @(negedge clk);
            if (!s_rvalid || s_rdata !== data || s_rresp !== resp) stable = 0;
        end
        if (r_hold > 0) check("rvalid_rdata_held", 32'(stable), 32'd1);
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        @(negedge clk);
        check("arready_return", 32'(s_arready), 32'd1);
        ok = 1;
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        int          lead;
        int          hold;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    function automatic vec_t vw(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                                input int lead, input int hold, input logic [1:0] r);
        vec_t v;
        v.wr = 1; v.addr = a; v.data = d; v.strb = s; v.lead = lead; v.hold = hold;
        v.exp_data = '0; v.exp_resp = r;
        return v;
    endfunction

    function automatic vec_t vr(input logic [31:0] a, input int hold,
                                input logic [31:0] ed, input logic [1:0] r);
        vec_t v;
        v.wr = 0; v.addr = a; v.data = '0; v.strb = '0; v.lead = 0; v.hold = hold;
        v.exp_data = ed; v.exp_resp = r;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] rd, a, d, wa, exp_d, mask;
        logic [1:0]  rsp, exp_r;
        logic [7:0]  s;
        int          lat;
        bit          ok, inr, seen;

        vecs.push_back(vw(32'h8000_0010, 32'hDEADBEEF, 8'h0F,  0, 0, 2'b00));
        vecs.push_back(vr(32'h8000_0010, 0, 32'hDEADBEEF, 2'b00));
        vecs.push_back(vw(32'h8000_0020, 32'h1122_3344, 8'h0F, 0, 0, 2'b00));
        vecs.push_back(vw(32'h8000_0020, 32'h0000_00AA, 8'h01, 0, 0, 2'b00));
        vecs.push_back(vr(32'h8000_0020, 0, 32'h1122_33AA, 2'b00));
        vecs.push_back(vw(32'h8000_0020, 32'hAABB_CCDD, 8'hF0, 0, 0, 2'b00));
        vecs.push_back(vr(32'h8000_0020, 2, 32'h1122_33AA, 2'b00));
        vecs.push_back(vw(32'h8000_0024, 32'h0102_0304, 8'h0F, 0, 0, 2'b00));
        vecs.push_back(vw(32'h8000_0024, 32'hCAFE_F00D, 8'h0C, 2, 5, 2'b00));
        vecs.push_back(vr(32'h8000_0024, 0, 32'hCAFE_0304, 2'b00));
        vecs.push_back(vr(32'h7FFF_FFFC, 0, 32'h0, 2'b11));
        vecs.push_back(vw(32'h8000_0000, 32'h1357_9BDF, 8'h0F, -1, 0, 2'b00));
        vecs.push_back(vw(32'h8000_4000, 32'hFFFF_FFFF, 8'h0F, 0, 0, 2'b11));
        vecs.push_back(vr(32'h8000_4000, 0, 32'h0, 2'b11));
        vecs.push_back(vr(32'h8000_0000, 0, 32'h1357_9BDF, 2'b00));
        vecs.push_back(vw(32'h8000_3FFC, 32'h5A5A_5A5A, 8'h0F, 1, 1, 2'b00));
        vecs.push_back(vr(32'h8000_3FFF, 0, 32'h5A5A_5A5A, 2'b00));
        vecs.push_back(vw(32'h8000_0011, 32'h0000_7700, 8'h02, 0, 0, 2'b00));
        vecs.push_back(vr(32'h8000_0013, 0, 32'hDEAD_77EF, 2'b00));
        vecs.push_back(vw(32'h8000_0010, 32'hFFFF_FFFF, 8'h00, 0, 0, 2'b00));
        vecs.push_back(vr(32'h8000_0010, 0, 32'hDEAD_77EF, 2'b00));
        vecs.push_back(vw(32'hFFFF_FFFC, 32'h0000_0000, 8'h0F, 0, 0, 2'b11));
        vecs.push_back(vr(32'h8000_3FFC, 0, 32'h5A5A_5A5A, 2'b00));

        rst_a = 1; rst_b = 1; sel = 0;
        araddr = '0; awaddr = '0; wdata = '0; wstrb = '0;
        arvalid = 0; rready = 0; awvalid = 0; wvalid = 0; bready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", 32'(arready_a), 32'd0);
        check("rst_awready", 32'(awready_a), 32'd0);
        check("rst_wready",  32'(wready_a),  32'd0);
        check("rst_rvalid",  32'(rvalid_a),  32'd0);
        check("rst_bvalid",  32'(bvalid_a),  32'd0);
        check("rst_rdata",   rdata_a,        32'd0);
        check("rst_rresp",   32'(rresp_a),   32'd0);
        check("rst_bresp",   32'(bresp_a),   32'd0);
        check("rst_b_arready", 32'(arready_b), 32'd0);
        @(posedge clk); #1;
        rst_a = 0;
        @(negedge clk);
        check("arready_first_cycle", 32'(arready_a), 32'd1);

        // Table-driven directed vectors on the zero-latency instance.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].lead,
                         vecs[i].hold, rsp, lat, ok);
                if (ok) begin
                    check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
                    check_lat($sformatf("vec%0d_wlat", i), lat, 0);
                end
            end else begin
                do_read(vecs[i].addr, vecs[i].hold, rd, rsp, lat, ok);
                if (ok) begin
                    check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
                    check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                    check_lat($sformatf("vec%0d_rlat", i), lat, 0);
                end
            end
        end

`ifndef AXI_SRAM_RAND_DELAY_EN
        // Read and write to one word accepted in the same cycle: old data.
        do_write(32'h8000_0030, 32'h0BAD_CAFE, 8'h0F, 0, 0, rsp, lat, ok);
        @(posedge clk); #1;
        awaddr = 32'h8000_0030; wdata = 32'h600D_F00D; wstrb = 8'h0F;
        araddr = 32'h8000_0030;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        @(negedge clk);
        check("same_cycle_readies", {29'd0, s_arready, s_awready, s_wready}, 32'd7);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        @(negedge clk);
        check("same_cycle_valids", {30'd0, s_rvalid, s_bvalid}, 32'd3);
        check("same_cycle_old_data", s_rdata, 32'h0BAD_CAFE);
        @(posedge clk); #1;
        bready = 0; rready = 0;
        do_read(32'h8000_0030, 0, rd, rsp, lat, ok);
        if (ok) check("later_read_new_data", rd, 32'h600D_F00D);
`endif

        // Randomised traffic against the byte-level model.
        for (int i = 0; i < 200; i++) begin
            int pick;
            pick = int'($urandom_range(0, 9));
            if (pick < 8)
                a = BASE + 32'h1000 + (32'($urandom_range(0, 31)) << 2) + 32'($urandom_range(0, 3));
            else if (pick == 8)
                a = BASE - (32'($urandom_range(1, 16)) << 2);
            else
                a = BASE + 32'h4000 + (32'($urandom_range(0, 255)) << 2);
            inr = m_in_range(a);
            wa  = {a[31:2], 2'b00};
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 8'($urandom_range(0, 255));
                do_write(a, d, s, int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)),
                         rsp, lat, ok);
                if (ok) begin
                    check("rand_bresp", 32'(rsp), inr ? 32'd0 : 32'd3);
                    check_lat("rand_wlat", lat, 0);
                end
                if (inr)
                    for (int k = 0; k < 4; k++)
                        if (s[k]) bmem[wa + 32'(k)] = d[8*k +: 8];
            end else begin
                do_read(a, int'($urandom_range(0, 2)), rd, rsp, lat, ok);
                exp_r = inr ? 2'b00 : 2'b11;
                exp_d = '0;
                mask  = inr ? 32'd0 : 32'hFFFF_FFFF;
                if (inr)
                    for (int k = 0; k < 4; k++)
                        if (bmem.exists(wa + 32'(k))) begin
                            exp_d[8*k +: 8] = bmem[wa + 32'(k)];
                            mask[8*k +: 8]  = 8'hFF;
                        end
                if (ok) begin
                    check("rand_rresp", 32'(rsp), 32'(exp_r));
                    check_lat("rand_rlat", lat, 0);
                    if (mask != 0) check("rand_rdata", rd & mask, exp_d);
                end
            end
        end

`ifndef AXI_SRAM_RAND_DELAY_EN
        // FIXED_LAT=3 instance.
        @(posedge clk); #1;
        rst_a = 1; sel = 1; rst_b = 0;
        do_write(32'h8000_0040, 32'h1111_1111, 8'h0F, 0, 0, rsp, lat, ok);
        if (ok) begin
            check("b_bresp", 32'(rsp), 32'd0);
            check_lat("b_wlat", lat, 3);
        end
        do_read(32'h8000_0040, 0, rd, rsp, lat, ok);
        if (ok) begin
            check("b_rdata", rd, 32'h1111_1111);
            check_lat("b_rlat", lat, 3);
        end

        // Reset while the read waits: no response ever appears.
        @(posedge clk); #1;
        araddr = 32'h8000_0040; arvalid = 1; rready = 1;
        @(posedge clk); #1;
        arvalid = 0; rst_b = 1;
        seen = 0;
        @(negedge clk);
        check("arready_in_rst", 32'(s_arready), 32'd0);
        seen = seen | s_rvalid;
        @(posedge clk); #1;
        rst_b = 0;
        @(negedge clk);
        check("arready_after_rst", 32'(s_arready), 32'd1);
        repeat (10) begin
            seen = seen | s_rvalid;
            @(negedge clk);
        end
        check("no_rvalid_after_rst", 32'(seen), 32'd0);
        rready = 0;

        // Reset while the write waits: not committed, no response.
        @(posedge clk); #1;
        awaddr = 32'h8000_0040; wdata = 32'h2222_2222; wstrb = 8'h0F;
        awvalid = 1; wvalid = 1; bready = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; rst_b = 1;
        @(posedge clk); #1;
        rst_b = 0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | s_bvalid;
        end
        check("no_bvalid_after_rst", 32'(seen), 32'd0);
        bready = 0;
        do_read(32'h8000_0040, 0, rd, rsp, lat, ok);
        if (ok) check("dropped_write_not_committed", rd, 32'h1111_1111);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
